// File: rtl/serial_det_sequencer.sv
// Purpose : frame controller; takes a parallel word, shifts it MSB-first into a
//           serial detector, counts detector hits over an aligned window, reports the count.
// Latency : accept edge to out_valid = WIDTH+DET_LAT cycles (+1 with DET_FLUSH_EN).
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
//
// Optional feature macro: DET_FLUSH_EN
//   defined   -> one FLUSH cycle with det_clr=1 before every frame
//   undefined -> no FLUSH state, det_clr tied low, detector state spans frames
//
// Ports:
//   clk, rst            single rising-edge clock, async active-low reset
//   in_valid/in_ready   host frame handshake, in_data = frame word (MSB first)
//   ser_j, ser_en       serial bit to detector and its qualifier
//   det_w               detector hit output
//   det_clr             one-cycle detector clear (DET_FLUSH_EN only)
//   out_valid/out_ready result handshake, out_count = hits in frame (saturating)

module serial_det_sequencer #(
    parameter int WIDTH   = 8,
    parameter int CNT_W   = 4,
    parameter int DET_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             ser_j,
    output logic             ser_en,
    input  logic             det_w,
    output logic             det_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count
);

    // r_cyc counts cycles from SHIFT cycle 0 through the last DRAIN cycle.
    localparam int CYC_W = $clog2(WIDTH + DET_LAT + 1);
    localparam logic [CYC_W-1:0] SHIFT_LAST = CYC_W'(WIDTH - 1);
    localparam logic [CYC_W-1:0] DRAIN_LAST = CYC_W'(WIDTH + DET_LAT - 1);
    localparam logic [CYC_W-1:0] WIN_FIRST  = CYC_W'(DET_LAT);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
`ifdef DET_FLUSH_EN
        S_FLUSH = 3'd1,
`endif
        S_SHIFT = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [WIDTH-1:0]   r_shift;
    logic [CYC_W-1:0]   r_cyc;
    logic [CNT_W-1:0]   r_count;
    logic               w_accept;
    logic               w_sample;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next state and state-decoded outputs. Outputs are pure decodes of
    // r_state so an asynchronous reset drives them to idle values at once.
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        ser_en       = 1'b0;
        ser_j        = 1'b0;
        det_clr      = 1'b0;
        out_valid    = 1'b0;
        w_accept     = 1'b0;
        w_sample     = 1'b0;

        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept = 1'b1;
`ifdef DET_FLUSH_EN
                    w_next_state = S_FLUSH;
`else
                    w_next_state = S_SHIFT;
`endif
                end
            end

`ifdef DET_FLUSH_EN
            S_FLUSH: begin
                det_clr      = 1'b1;
                w_next_state = S_SHIFT;
            end
`endif

            S_SHIFT: begin
                ser_en = 1'b1;
                ser_j  = r_shift[WIDTH-1];
                // Early SHIFT cycles see the detector's response to the
                // previous frame / flush, not to this frame's bits.
                w_sample = (r_cyc >= WIN_FIRST);
                if (r_cyc == SHIFT_LAST) begin
                    w_next_state = (DET_LAT == 0) ? S_DONE : S_DRAIN;
                end
            end

            S_DRAIN: begin
                // Every DRAIN cycle lies inside the window: it carries the
                // delayed responses to the last DET_LAT frame bits.
                w_sample = 1'b1;
                if (r_cyc == DRAIN_LAST) begin
                    w_next_state = S_DONE;
                end
            end

            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next_state = S_IDLE;
                end
            end

            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: shift register, window cycle counter, saturating hit count
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift <= '0;
            r_cyc   <= '0;
            r_count <= '0;
        end else begin
            if (w_accept) begin
                r_shift <= in_data;
                r_cyc   <= '0;
                r_count <= '0;
            end else begin
                if (r_state == S_SHIFT) begin
                    r_shift <= {r_shift[WIDTH-2:0], 1'b0};
                end
                if ((r_state == S_SHIFT) || (r_state == S_DRAIN)) begin
                    r_cyc <= r_cyc + 1'b1;
                end
                if (w_sample && det_w && (r_count != CNT_MAX)) begin
                    r_count <= r_count + 1'b1;
                end
            end
        end
    end

    // Count is held after the result handshake until the next accept.
    assign out_count = r_count;

endmodule

// File: tb/tb_serial_det_sequencer.sv
// Purpose : directed self-checking bench for serial_det_sequencer.
// Latency : checks accept-to-SHIFT and accept-to-out_valid cycle alignment.
// Backpressure: holds out_ready low in DONE and verifies the result is stable.
//
// Two instances run in lockstep on shared inputs: the default configuration
// (WIDTH=8, CNT_W=4, DET_LAT=1) and a CNT_W=2 copy used for saturation.

module tb_serial_det_sequencer;

    localparam int WIDTH   = 8;
    localparam int DET_LAT = 1;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       ser_j;
    logic       ser_en;
    logic       det_w;
    logic       det_clr;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_count;

    logic       sat_in_ready;
    logic       sat_ser_j;
    logic       sat_ser_en;
    logic       sat_det_clr;
    logic       sat_out_valid;
    logic [1:0] sat_out_count;

    int n_checks;
    int n_fail;

    serial_det_sequencer #(.WIDTH(WIDTH), .CNT_W(4), .DET_LAT(DET_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .ser_j     (ser_j),
        .ser_en    (ser_en),
        .det_w     (det_w),
        .det_clr   (det_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count)
    );

    serial_det_sequencer #(.WIDTH(WIDTH), .CNT_W(2), .DET_LAT(DET_LAT)) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (sat_in_ready),
        .in_data   (in_data),
        .ser_j     (sat_ser_j),
        .ser_en    (sat_ser_en),
        .det_w     (det_w),
        .det_clr   (sat_det_clr),
        .out_valid (sat_out_valid),
        .out_ready (out_ready),
        .out_count (sat_out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Called at a negedge with the DUTs in IDLE. mask[t] drives det_w at
    // offset t from SHIFT cycle 0; the window is offsets 1..8 for DET_LAT=1.
    task automatic run_frame(input logic [7:0] data, input logic [15:0] mask,
                             input int exp_cnt, input int exp_sat, input int hold);
        logic [7:0] got;
        int en_cnt;
        int clr_cnt;
        got     = '0;
        en_cnt  = 0;
        clr_cnt = 0;

        check_eq("idle_in_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = data;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'h00;
`ifdef DET_FLUSH_EN
        check_eq("flush_det_clr", {31'd0, det_clr}, 32'd1);
        check_eq("flush_ser_en", {31'd0, ser_en}, 32'd0);
        @(negedge clk);
`endif
        check_eq("busy_in_ready", {31'd0, in_ready}, 32'd0);
        for (int t = 0; t < 10; t++) begin
            det_w = mask[t];
            if (t < WIDTH) got = {got[6:0], ser_j};
            en_cnt  += int'(ser_en);
            clr_cnt += int'(det_clr);
            if (t == 8) check_eq("out_valid_early", {31'd0, out_valid}, 32'd0);
            if (t == 9) check_eq("out_valid_on_time", {31'd0, out_valid}, 32'd1);
            @(negedge clk);
        end
        det_w = 1'b0;
        check_eq("ser_bits", {24'd0, got}, {24'd0, data});
        check_eq("ser_en_cycles", en_cnt, 32'd8);
        check_eq("no_clr_in_frame", clr_cnt, 32'd0);
        check_eq("out_count", {28'd0, out_count}, exp_cnt);
        check_eq("sat_out_count", {30'd0, sat_out_count}, exp_sat);

        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_data  = 8'hFF;
            check_eq("hold_in_ready", {31'd0, in_ready}, 32'd0);
            check_eq("hold_out_valid", {31'd0, out_valid}, 32'd1);
            check_eq("hold_out_count", {28'd0, out_count}, exp_cnt);
            @(negedge clk);
        end

        // in_valid stays high across the result handshake edge; it must not
        // be taken in that same cycle.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("post_hs_in_ready", {31'd0, in_ready}, 32'd1);
        check_eq("post_hs_out_valid", {31'd0, out_valid}, 32'd0);
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        det_w     = 1'b0;
        out_ready = 1'b0;

        // Reset held
        repeat (3) @(negedge clk);
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_eq("rst_ser_en", {31'd0, ser_en}, 32'd0);
        check_eq("rst_ser_j", {31'd0, ser_j}, 32'd0);
        check_eq("rst_det_clr", {31'd0, det_clr}, 32'd0);
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_out_count", {28'd0, out_count}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Reset asserted in the middle of SHIFT
        in_valid = 1'b1;
        in_data  = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
`ifdef DET_FLUSH_EN
        @(negedge clk);
`endif
        det_w = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("pre_rst_ser_en", {31'd0, ser_en}, 32'd1);
        check_eq("pre_rst_count", {28'd0, out_count}, 32'd2);
        rst = 1'b0;
        #1;
        check_eq("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check_eq("midrst_ser_en", {31'd0, ser_en}, 32'd0);
        check_eq("midrst_ser_j", {31'd0, ser_j}, 32'd0);
        check_eq("midrst_det_clr", {31'd0, det_clr}, 32'd0);
        check_eq("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("midrst_out_count", {28'd0, out_count}, 32'd0);
        det_w = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("post_rst_no_clr", {31'd0, det_clr}, 32'd0);
            check_eq("post_rst_idle", {31'd0, in_ready}, 32'd1);
        end

        // Hits at offsets 1,3,5
        run_frame(8'hA5, 16'h002A, 3, 3, 0);
        // Hits only outside the window (offsets 0 and 9)
        run_frame(8'h3C, 16'h0201, 0, 0, 0);
        // Hit at last window offset
        run_frame(8'h81, 16'h0100, 1, 1, 0);
        // Hits everywhere: 8 in window, CNT_W=2 copy saturates at 3
        run_frame(8'hFF, 16'h03FF, 8, 3, 0);
        // Backpressure for 5 cycles in DONE
        run_frame(8'h5A, 16'h002A, 3, 3, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: got no completion expected completion");
        $fatal(1);
    end

endmodule

// File: doc/serial_det_sequencer.md
# serial_det_sequencer

Frame controller for the serial sequence-detector datapath. Accepts a parallel word over a valid/ready handshake, shifts it MSB-first into an external serial detector (j input), samples the detector's w output over an aligned window, and reports the number of detector hits for that frame over a second valid/ready handshake. Sits between the parallel host interface and the single-bit detector core; it owns sequencing and optional per-frame detector clearing.

## Interface
- WIDTH, 8, bits per frame (≥2)
- CNT_W, 4, hit counter width; must satisfy 2^CNT_W−1 ≥ WIDTH for exact counts
- DET_LAT, 1, cycles from a bit presented on ser_j to its w response (0..3)

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  host frame valid
- in_ready  out  1  controller can accept a frame
- in_data  in  WIDTH  frame bits, MSB shifted first
- ser_j  out  1  serial bit to detector j input
- ser_en  out  1  high while ser_j carries a frame bit
- det_w  in  1  detector w output
- det_clr  out  1  one-cycle detector clear (only with DET_FLUSH_EN)
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_count  out  CNT_W  detector hits in the frame

## Operation
- States: IDLE, FLUSH (only with DET_FLUSH_EN), SHIFT, DRAIN, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, latch in_data into shift register, clear hit counter, go to FLUSH (or SHIFT if macro absent).
- FLUSH: one cycle, det_clr=1, ser_en=0 → SHIFT.
- SHIFT: exactly WIDTH cycles; ser_en=1, ser_j=current MSB; shift left each cycle. Bit k (k=0..WIDTH−1) is presented in SHIFT cycle k. → DRAIN, or → DONE if DET_LAT=0.
- DRAIN: DET_LAT cycles, ser_en=0, ser_j=0 → DONE.
- Sample window: det_w counted in cycles DET_LAT..WIDTH−1+DET_LAT, measured from SHIFT cycle 0 (spans SHIFT and DRAIN). det_w outside the window is ignored.
- Counter increments by 1 per sampled det_w=1 and saturates at 2^CNT_W−1.
- DONE: out_valid=1, out_count stable; on out_valid&out_ready → IDLE.
- in_ready=0 in every state except IDLE; in_data and in_valid are ignored there.

## Timing
- Reset values: in_ready=1, ser_j=0, ser_en=0, det_clr=0, out_valid=0, out_count=0, state IDLE.
- Reset asserted mid-frame: all outputs return to reset values asynchronously; frame and partial count discarded; no det_clr issued.
- Accept edge to first SHIFT cycle: 2 cycles with macro, 1 without.
- Accept edge to out_valid high: 1+WIDTH+DET_LAT cycles with macro, WIDTH+DET_LAT without.
- out_valid and out_count hold unchanged while out_ready=0.
- Result handshake edge to in_ready=1: next cycle (no same-cycle frame accept).
- out_count keeps last value after handshake until the next frame's first increment or clear; only valid when out_valid=1.

## Configuration
- DET_FLUSH_EN defined: FLUSH state present; det_clr pulses high for exactly one cycle before every frame so detector state never spans frames.
- DET_FLUSH_EN undefined: no FLUSH state, det_clr tied 0; detector state carries across frames and latency is one cycle shorter.

## Test plan
- Reset: hold rst=0 → in_ready=1, ser_en=0, ser_j=0, det_clr=0, out_valid=0, out_count=0; assert rst=0 mid-SHIFT → same values immediately.
- Serialization: in_data=8'hA5 → ser_j = 1,0,1,0,0,1,0,1 with ser_en high exactly 8 consecutive cycles; with macro, det_clr high one cycle just before.
- Counting (DET_LAT=1): det_w high at window offsets 1,3,5 → out_valid after 10 cycles (macro) / 9 (no macro), out_count=3.
- Window edges: det_w high only at offset 0 and offset 9 (outside window) → out_count=0; det_w high at offset 8 → out_count=1.
- Backpressure: out_ready=0 for 5 cycles in DONE → out_valid=1, out_count stable, in_ready=0, in_valid ignored; out_ready=1 → in_ready=1 next cycle.
- Saturation: CNT_W=2, det_w high for whole window → out_count=3.
